// File: rtl/switch_arbiter_rr.sv
// Per-output round-robin switch arbiter with wormhole locking and output backpressure.
// Each output keeps owner/locked/ptr state; select and sel_valid come straight from those registers.
module switch_arbiter_rr #(
  parameter int N_PORTS = 5,
  parameter int PORT_W  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          req_valid,
  input  logic [N_PORTS*PORT_W-1:0]   req_dest,
  input  logic [N_PORTS-1:0]          req_tail,
  input  logic [N_PORTS-1:0]          out_ready,
  output logic [N_PORTS-1:0]          ack,
  output logic [N_PORTS*PORT_W-1:0]   select,
  output logic [N_PORTS-1:0]          sel_valid
);

  logic [PORT_W-1:0]  owner_q [N_PORTS];
  logic [PORT_W-1:0]  owner_d [N_PORTS];
  logic [PORT_W-1:0]  ptr_q   [N_PORTS];
  logic [PORT_W-1:0]  ptr_d   [N_PORTS];
  logic [N_PORTS-1:0] locked_q;
  logic [N_PORTS-1:0] locked_d;

  logic [PORT_W-1:0]  dest [N_PORTS];
  logic [N_PORTS-1:0] tailXfer;

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      dest[i] = req_dest[i*PORT_W +: PORT_W];
    end
  end

  // Destinations outside 0..N_PORTS-1 never match an output, so they are never acked.
  always_comb begin
    ack = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      for (int o = 0; o < N_PORTS; o++) begin
        if (req_valid[i] && (dest[i] == PORT_W'(o)) && locked_q[o] &&
            (owner_q[o] == PORT_W'(i)) && out_ready[o]) begin
          ack[i] = 1'b1;
        end
      end
    end
  end

  assign tailXfer = ack & req_tail;

  // A releasing output re-arbitrates on the same edge, searching from its updated pointer,
  // so back-to-back packets from different inputs lose no cycle.
  always_comb begin
    logic releaseNow;
    logic found;
    int   idx;
    for (int o = 0; o < N_PORTS; o++) begin
      owner_d[o]  = owner_q[o];
      ptr_d[o]    = ptr_q[o];
      locked_d[o] = locked_q[o];
      releaseNow  = 1'b0;
      found       = 1'b0;
      idx         = 0;

      for (int i = 0; i < N_PORTS; i++) begin
        if (locked_q[o] && (owner_q[o] == PORT_W'(i)) && tailXfer[i] &&
            (dest[i] == PORT_W'(o))) begin
          releaseNow = 1'b1;
        end
      end

      if (releaseNow) begin
        locked_d[o] = 1'b0;
        ptr_d[o]    = (owner_q[o] == PORT_W'(N_PORTS - 1)) ? '0 : owner_q[o] + 1'b1;
      end

      if (!locked_q[o] || releaseNow) begin
        for (int k = 0; k < N_PORTS; k++) begin
          idx = (int'(ptr_d[o]) + k) % N_PORTS;
          if (!found && req_valid[idx] && (dest[idx] == PORT_W'(o)) && !tailXfer[idx]) begin
            found       = 1'b1;
            locked_d[o] = 1'b1;
            owner_d[o]  = PORT_W'(idx);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked_q <= '0;
      for (int o = 0; o < N_PORTS; o++) begin
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      locked_q <= locked_d;
      for (int o = 0; o < N_PORTS; o++) begin
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

  always_comb begin
    for (int o = 0; o < N_PORTS; o++) begin
      select[o*PORT_W +: PORT_W] = owner_q[o];
    end
  end

  assign sel_valid = locked_q;

endmodule

// File: tb/tb_switch_arbiter_rr.sv
// Directed self-checking bench for switch_arbiter_rr (5 ports, 3-bit indices).
// Expected values below are hand-derived from the arbitration rules.
module tb_switch_arbiter_rr;

  localparam int N_PORTS = 5;
  localparam int PORT_W  = 3;

  logic                       clk;
  logic                       rst;
  logic [N_PORTS-1:0]         req_valid;
  logic [N_PORTS*PORT_W-1:0]  req_dest;
  logic [N_PORTS-1:0]         req_tail;
  logic [N_PORTS-1:0]         out_ready;
  logic [N_PORTS-1:0]         ack;
  logic [N_PORTS*PORT_W-1:0]  select;
  logic [N_PORTS-1:0]         sel_valid;

  int errors = 0;
  int checks = 0;

  switch_arbiter_rr #(.N_PORTS(N_PORTS), .PORT_W(PORT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_dest  (req_dest),
    .req_tail  (req_tail),
    .out_ready (out_ready),
    .ack       (ack),
    .select    (select),
    .sel_valid (sel_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input bit v, input int d, input bit t);
    logic [31:0] dv;
    dv = d;
    req_valid[port] = v;
    req_dest[port*PORT_W +: PORT_W] = dv[PORT_W-1:0];
    req_tail[port] = t;
  endtask

  function automatic logic [31:0] selOf(input int o);
    return 32'(select[o*PORT_W +: PORT_W]);
  endfunction

  task automatic clearInputs();
    req_valid = '0;
    req_dest  = '0;
    req_tail  = '0;
    out_ready = '1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  initial begin
    clearInputs();
    rst = 1'b0;

    // Reset held with random inputs, then released with no requests.
    for (int c = 0; c < 3; c++) begin
      req_valid = N_PORTS'($urandom);
      req_dest  = (N_PORTS*PORT_W)'($urandom);
      req_tail  = N_PORTS'($urandom);
      out_ready = N_PORTS'($urandom);
      nextCycle();
      checkOutput("rst_ack", 32'(ack), 32'd0);
      checkOutput("rst_selv", 32'(sel_valid), 32'd0);
      checkOutput("rst_sel", 32'(select), 32'd0);
    end
    clearInputs();
    #2 rst = 1'b1;
    nextCycle();
    nextCycle();
    checkOutput("idle_ack", 32'(ack), 32'd0);
    checkOutput("idle_selv", 32'(sel_valid), 32'd0);
    checkOutput("idle_sel", 32'(select), 32'd0);

    // Single-flit packet input 2 -> output 1.
    applyStimulus(2, 1'b1, 1, 1'b1);
    #1 checkOutput("sf_ack_pre", 32'(ack), 32'd0);
    nextCycle();
    checkOutput("sf_selv", 32'(sel_valid), 32'b00010);
    checkOutput("sf_sel1", selOf(1), 32'd2);
    checkOutput("sf_ack", 32'(ack), 32'b00100);
    nextCycle();
    checkOutput("sf_selv_rel", 32'(sel_valid), 32'd0);
    checkOutput("sf_ack_rel", 32'(ack), 32'd0);
    clearInputs();

    // Round robin: inputs 0, 3, 4 persistently send single-flit packets to output 2.
    applyStimulus(0, 1'b1, 2, 1'b1);
    applyStimulus(3, 1'b1, 2, 1'b1);
    applyStimulus(4, 1'b1, 2, 1'b1);
    doReset();
    #1 checkOutput("rr_ack_pre", 32'(ack), 32'd0);
    begin
      int order[6] = '{0, 3, 4, 0, 3, 4};
      for (int c = 0; c < 6; c++) begin
        nextCycle();
        checkOutput($sformatf("rr_sel_%0d", c), selOf(2), 32'(order[c]));
        checkOutput($sformatf("rr_ack_%0d", c), 32'(ack), 32'(1 << order[c]));
      end
    end
    clearInputs();

    // Wormhole lock: input 1 sends 4 flits to output 3, input 0 waits behind it.
    doReset();
    applyStimulus(1, 1'b1, 3, 1'b0);
    nextCycle();
    applyStimulus(0, 1'b1, 3, 1'b1);
    #1;
    checkOutput("wh_sel3", selOf(3), 32'd1);
    checkOutput("wh_ack_f1", 32'(ack), 32'b00010);
    nextCycle();
    out_ready[3] = 1'b0;
    #1;
    checkOutput("wh_stall1_ack", 32'(ack), 32'd0);
    checkOutput("wh_stall1_sel", selOf(3), 32'd1);
    nextCycle();
    checkOutput("wh_stall2_ack", 32'(ack), 32'd0);
    checkOutput("wh_stall2_selv", 32'(sel_valid), 32'b01000);
    nextCycle();
    out_ready[3] = 1'b1;
    #1 checkOutput("wh_ack_f2", 32'(ack), 32'b00010);
    nextCycle();
    checkOutput("wh_ack_f3", 32'(ack), 32'b00010);
    nextCycle();
    applyStimulus(1, 1'b1, 3, 1'b1);
    #1 checkOutput("wh_ack_tail", 32'(ack), 32'b00010);
    nextCycle();
    applyStimulus(1, 1'b0, 3, 1'b0);
    #1;
    checkOutput("wh_next_sel", selOf(3), 32'd0);
    checkOutput("wh_next_ack", 32'(ack), 32'b00001);
    nextCycle();
    checkOutput("wh_done_selv", 32'(sel_valid), 32'd0);
    clearInputs();

    // Parallel outputs plus an out-of-range destination on input 3.
    doReset();
    applyStimulus(0, 1'b1, 4, 1'b1);
    applyStimulus(1, 1'b1, 3, 1'b1);
    applyStimulus(2, 1'b1, 0, 1'b1);
    applyStimulus(3, 1'b1, 6, 1'b1);
    #1 checkOutput("par_ack_pre", 32'(ack), 32'd0);
    nextCycle();
    checkOutput("par_ack", 32'(ack), 32'b00111);
    checkOutput("par_selv", 32'(sel_valid), 32'b11001);
    checkOutput("par_sel", 32'(select), 32'h0202);
    nextCycle();
    req_valid[2:0] = '0;
    #1;
    checkOutput("par_rel_ack", 32'(ack), 32'd0);
    checkOutput("par_rel_selv", 32'(sel_valid), 32'd0);
    nextCycle();
    checkOutput("bad_dest_selv", 32'(sel_valid), 32'd0);
    clearInputs();

    // Reset in the middle of a 3-flit packet; pointer state must not survive.
    doReset();
    applyStimulus(0, 1'b1, 2, 1'b1);
    applyStimulus(1, 1'b1, 2, 1'b0);
    nextCycle();
    checkOutput("mr_sel_a", selOf(2), 32'd0);
    checkOutput("mr_ack_a", 32'(ack), 32'b00001);
    nextCycle();
    applyStimulus(0, 1'b0, 2, 1'b0);
    #1;
    checkOutput("mr_sel_b", selOf(2), 32'd1);
    checkOutput("mr_ack_b", 32'(ack), 32'b00010);
    nextCycle();
    checkOutput("mr_ack_f2", 32'(ack), 32'b00010);
    #1 rst = 1'b0;
    #1;
    checkOutput("mr_rst_selv", 32'(sel_valid), 32'd0);
    checkOutput("mr_rst_sel", 32'(select), 32'd0);
    checkOutput("mr_rst_ack", 32'(ack), 32'd0);
    applyStimulus(1, 1'b0, 2, 1'b0);
    applyStimulus(0, 1'b1, 2, 1'b1);
    applyStimulus(3, 1'b1, 2, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    nextCycle();
    checkOutput("mr_new_sel", selOf(2), 32'd0);
    checkOutput("mr_new_selv", 32'(sel_valid), 32'b00100);
    checkOutput("mr_new_ack", 32'(ack), 32'b00001);
    clearInputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/switch_arbiter_rr.md
Name: switch_arbiter_rr

Overview:
- Parametrised successor of the NoC router switch arbiter.
- Serves N_PORTS inputs and N_PORTS outputs (default 5: L, N, E, S, W = indices 0..4).
- Per-output round-robin arbitration with wormhole packet locking: an output stays owned by one input from head grant until that input's tail flit transfers.
- Adds output backpressure. Sits between the input buffers and the crossbar; the select bus drives the crossbar muxes.

Parameters:
- N_PORTS, 5, number of input/output ports (2..8).
- PORT_W, 3, width of a port index; must satisfy 2**PORT_W >= N_PORTS.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  N_PORTS  input i holds a flit wanting to move.
- req_dest  in  N_PORTS*PORT_W  destination output of input i, in slice [i*PORT_W +: PORT_W].
- req_tail  in  N_PORTS  flit at input i is the last of its packet (single-flit packet: head = tail).
- out_ready  in  N_PORTS  output o can accept a flit this cycle.
- ack  out  N_PORTS  flit at input i transfers this cycle.
- select  out  N_PORTS*PORT_W  source input index for output o, in slice [o*PORT_W +: PORT_W].
- sel_valid  out  N_PORTS  output o is currently owned.

Behaviour:
- State per output o:
  - owner[o] (PORT_W bits)
  - locked[o] (1 bit)
  - ptr[o] (PORT_W bits): highest-priority candidate for the next grant.
- Reset (rst = 0, asynchronous): locked = 0, owner = 0, ptr = 0 for every output. Hence select = 0, sel_valid = 0, ack = 0. A reset mid-packet drops all locks; no partial state survives.
- Outputs:
  - select = owner and sel_valid = locked, both registered.
  - ack[i] is combinational: ack[i] = req_valid[i] & locked[d] & (owner[d] == i) & out_ready[d], with d = req_dest[i].
- Transfer: input i transfers in a cycle where ack[i] = 1.
- Release: output o releases at a clock edge where its owner transfers with req_tail = 1. At that edge locked[o] <= 0 and ptr[o] <= (owner + 1) mod N_PORTS.
- Grant: at each edge, an output that is unlocked, or releasing at this edge, grants the first eligible input found by searching ptr[o], ptr[o]+1, ... modulo N_PORTS.
  - Eligible: req_valid = 1, req_dest = o, and the input is not transferring a tail at this edge.
  - On grant: locked[o] <= 1, owner[o] <= winner. ptr is unchanged on grant.
  - If no input is eligible, the output stays unlocked.
- Latency:
  - Head request visible at edge t → sel_valid/select at t+1 → first possible ack in cycle t+1.
  - Back-to-back packets from different inputs to the same output lose no cycle.
- Lock persistence:
  - While locked, req_valid = 0 from the owner (bubble) or out_ready = 0 holds the lock with ack = 0.
  - A locked output ignores all other requesters.
- Each input requests exactly one destination, so it is acked by at most one output. req_dest must stay stable from head to tail; the arbiter does not check this.
- Destinations >= N_PORTS are never granted or acked. They do not disturb any output.
- Simultaneous events: tail release and new grant occur on the same edge on one output. Independent outputs arbitrate in parallel with no interaction.
- Fairness: with k persistent requesters on one output, each gets one packet per k packets.

Test Plan:
- Reset: hold rst = 0 with random inputs → ack = 0, sel_valid = 0, select = 0. Release rst with no requests → all stay 0.
- Single-flit packet: req_valid[2] = 1, req_dest[2] = 1, req_tail[2] = 1, out_ready = all 1 → sel_valid[1] = 1 and select[1] = 2 at the next edge, ack[2] = 1 for one cycle, sel_valid[1] = 0 after the following edge.
- Round robin: inputs 0, 3, 4 all send single-flit packets to output 2 continuously from reset → grant order 0, 3, 4, 0, … Ack every cycle after the first, with no gaps.
- Wormhole lock: input 1 sends a 4-flit packet to output 3 while input 0 requests output 3 → input 0 acked only in the cycle after input 1's tail. out_ready[3] = 0 for 2 cycles mid-packet stalls ack[1] and keeps select[3] = 1.
- Parallelism and bad destination: inputs 0→4, 1→3, 2→0 at the same time → all three acked in the same cycle. Input 3 with dest 6 → never acked.
- Reset mid-packet: assert rst = 0 during a 3-flit packet → sel_valid clears immediately. After release, a fresh head from another input wins from ptr = 0.
